lif_neuron_refractory: RTL

//  Leaky integrate-and-fire neuron stage, directly downstream of the synaptic input-current summer.

---
 rtl/lif_neuron_refractory.sv | 85 ++++++++
 1 files changed

// File: rtl/lif_neuron_refractory.sv
// Leaky integrate-and-fire neuron with saturating membrane potential and a
// programmable refractory period counted in enabled steps.
module lif_neuron_refractory #(
  parameter int                 REF_W   = 4,
  parameter logic signed [7:0]  V_RESET = 8'sd0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [7:0]        input_current,
  input  logic signed [7:0]        threshold,
  input  logic [2:0]               decay_shift,
  input  logic [REF_W-1:0]         refractory_period,
  output logic signed [7:0]        membrane_potential,
  output logic                     spike_out,
  output logic                     refractory
);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  state_t                  state;
  logic [REF_W-1:0]        counter;
  logic signed [7:0]       v;
  logic signed [7:0]       leak;
  logic signed [9:0]       sum;
  logic signed [7:0]       s;
  logic                    fire;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    leak = 8'sd0;
    if (decay_shift != 3'd0) leak = v >>> decay_shift;

    // v and leak share a sign, so v - leak never exceeds |v|; 10 bits holds the full sum.
    sum = {{2{v[7]}}, v} - {{2{leak[7]}}, leak} + {{2{input_current[7]}}, input_current};

    s = sum[7:0];
    if (sum > 10'sd127)        s = 8'sd127;
    else if (sum < -10'sd128)  s = -8'sd128;

    fire = (s >= threshold);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v         <= V_RESET;
      spike_out <= 1'b0;
      counter   <= '0;
      state     <= INTEGRATE;
    end else if (!enable) begin
      spike_out <= 1'b0;
    end else begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            spike_out <= 1'b1;
            v         <= V_RESET;
            if (refractory_period != '0) begin
              counter <= refractory_period;
              state   <= REFRACTORY;
            end
          end else begin
            spike_out <= 1'b0;
            v         <= s;
          end
        end
        REFRACTORY: begin
          spike_out <= 1'b0;
          v         <= V_RESET;
          counter   <= counter - 1'b1;
          if (counter == REF_W'(1)) state <= INTEGRATE;
        end
        default: state <= INTEGRATE;
      endcase
    end
  end

  assign membrane_potential = v;
  assign refractory         = (state == REFRACTORY);

endmodule
